booth_mult_r4: RTL and testbench
================================

Name: booth_mult_r4

Overview:
- Parametrised radix-4 (modified) Booth sequential multiplier. It is the next-generation replacement for the team's 64x64 radix-2 iterative multiplier.
- Adds:
  - selectable signed/unsigned operation per transaction,
  - roughly half the iteration count,
  - a busy/done handshake with a clear.
- Sits on the ALU's multi-cycle execution path and is driven by the execute-stage controller.

Parameters:
- WIDTH, 64, operand width in bits; must be even and >= 4.
- ITER, (WIDTH+2)/2, derived constant (localparam): number of radix-4 iterations. It is 33 for WIDTH=64 and 5 for WIDTH=8.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- op_start  input  1  start request; sampled only in IDLE or DONE.
- op_clear  input  1  synchronous clear to IDLE.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured at start.
- multiplier  input  WIDTH  operand B; captured at start.
- multiplicand  input  WIDTH  operand A; captured at start.
- op_busy  output  1  iteration in progress.
- op_done  output  1  result valid; held until next start or clear.
- result  output  2*WIDTH  product.

Behaviour:
- Reset: asserting reset asynchronously forces the following, regardless of the current state:
  - state IDLE, count 0;
  - op_busy=0, op_done=0, result=0;
  - operand and partial-product registers all 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE --op_start--> BUSY.
  - BUSY --count==ITER-1--> DONE.
  - DONE --op_start--> BUSY.
  - DONE --op_clear--> IDLE.
  - IDLE --op_clear--> IDLE.
- Simultaneous events: op_clear has priority over op_start in the same cycle.
- Capture on the accepting edge (E0):
  - Operands are extended to WIDTH+2 bits: sign-extended if is_signed=1, zero-extended if 0.
  - The multiplicand register (M) holds the extended A.
  - The product register P (2*(WIDTH+2)+1 bits) is loaded with {0, extended B, 1'b0}.
  - count is loaded with 0.
  - op_done is cleared and the previous result is discarded (result reads 0 while BUSY).
- Iteration: one per edge E1..E_ITER.
  - Recode bit-triple P[2:0] into {0, +M, +2M, -M, -2M, 0}:
    - 000 and 111 -> 0;
    - 001 and 010 -> +M;
    - 011 -> +2M;
    - 100 -> -2M;
    - 101 and 110 -> -M.
  - Add the recoded value into the upper half of P.
  - Arithmetic-shift P right by 2.
  - count increments by 1.
- Completion:
  - At edge E_ITER the FSM enters DONE.
  - result = P[2*WIDTH:1], i.e. the low 2*WIDTH bits of the product proper.
  - op_busy is high exactly ITER cycles (from after E0 through E_ITER).
  - op_done rises after E_ITER, so latency from accept to done is ITER cycles.
- Width rules:
  - All adds are WIDTH+2 bits wide on the upper half of P.
  - -M is formed as ~M+1.
  - 2M is M shifted left by 1; this cannot overflow thanks to the 2-bit guard.
  - The result is exact for all operand values in both modes, including:
    - signed: A=B=-2^(WIDTH-1);
    - unsigned: A=B=2^WIDTH-1.
- Other boundary rules:
  - op_start while BUSY is ignored; operand inputs are don't-care while BUSY.
  - op_clear while BUSY aborts: state returns to IDLE, op_busy=0, op_done=0, result=0.
  - Back-to-back operation: op_start in the same cycle op_done is high is accepted. op_done drops after that edge and a new ITER-cycle operation begins, with zero idle cycles between results.
  - Inputs are captured only at the accepting edge; changing them afterwards has no effect.
- Implementation notes:
  - The counter is $clog2(ITER+1) bits wide.
  - There is no combinational path from inputs to outputs; op_busy, op_done and result are registered.

Test Plan:
- WIDTH=8, signed: A=-128, B=-128 -> op_done after exactly 5 busy cycles, result=16'h4000 (16384).
- WIDTH=8, unsigned: A=8'hFF, B=8'hFF -> result=16'hFE01.
- WIDTH=8, signed: A=8'hFF (-1), B=8'h7F (127) -> result=16'hFF81. Same operands with is_signed=0 -> result=16'h7E81 (255*127=32385).
- WIDTH=64, signed and unsigned, 2000 random operands compared against a reference model. Each check requires:
  - op_busy high exactly 33 cycles;
  - back-to-back op_start on the op_done cycle accepted with no gap.
- Abort and ignore cases:
  - op_clear at busy cycle 3 -> next cycle: IDLE, op_busy=0, op_done=0, result=0.
  - op_start held high throughout BUSY -> exactly one operation is executed.
- Asynchronous reset:
  - Reset pulse between clock edges mid-BUSY -> outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a new op_start with A=3, B=-5 (signed, WIDTH=8) -> result=16'hFFF1.

Source files
------------

// File: rtl/booth_mult_r4.sv
// Radix-4 modified Booth sequential multiplier.
// Signed/unsigned per transaction, busy/done handshake with clear.
module booth_mult_r4 #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 op_busy,
  output logic                 op_done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int ITER = (WIDTH + 2) / 2;
  localparam int EW   = WIDTH + 2;
  localparam int PW   = 2 * EW + 1;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [EW-1:0]      m_q, m_d;
  logic [PW-1:0]      p_q, p_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [EW-1:0]      a_ext;
  logic [EW-1:0]      b_ext;
  logic [EW-1:0]      neg_m;
  logic [EW-1:0]      pp;
  logic [EW-1:0]      sum;
  logic [PW-1:0]      p_step;
  logic               last;

  // Two guard bits make +/-2M and the running sum overflow-free.
  always_comb begin
    a_ext = {2'b00, multiplicand};
    b_ext = {2'b00, multiplier};
    if (is_signed) begin
      a_ext = {{2{multiplicand[WIDTH-1]}}, multiplicand};
      b_ext = {{2{multiplier[WIDTH-1]}}, multiplier};
    end
  end

  // Booth recoding of the low bit-triple of P into a partial product.
  always_comb begin
    neg_m = ~m_q + EW'(1);
    pp    = '0;
    unique case (p_q[2:0])
      3'b001, 3'b010: pp = m_q;
      3'b011:         pp = m_q << 1;
      3'b100:         pp = neg_m << 1;
      3'b101, 3'b110: pp = neg_m;
      default:        pp = '0;
    endcase
  end

  // Accumulate into the upper half, then arithmetic shift right by two.
  always_comb begin
    sum    = p_q[PW-1:EW+1] + pp;
    p_step = {{2{sum[EW-1]}}, sum, p_q[EW:2]};
    last   = (count_q == CW'(ITER - 1));
  end

  // Next-state and datapath control; clear wins over start.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    m_d      = m_q;
    p_d      = p_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    unique case (state_q)
      IDLE: begin
        if (op_clear) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b0;
          result_d = '0;
        end else if (op_start) begin
          state_d  = BUSY;
          count_d  = '0;
          m_d      = a_ext;
          p_d      = {{EW{1'b0}}, b_ext, 1'b0};
          result_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      BUSY: begin
        if (op_clear) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b0;
          result_d = '0;
        end else begin
          p_d     = p_step;
          count_d = count_q + CW'(1);
          if (last) begin
            state_d  = DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = p_step[2*WIDTH:1];
          end
        end
      end
      DONE: begin
        if (op_clear) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b0;
          result_d = '0;
        end else if (op_start) begin
          state_d  = BUSY;
          count_d  = '0;
          m_d      = a_ext;
          p_d      = {{EW{1'b0}}, b_ext, 1'b0};
          result_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = '0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      m_q      <= '0;
      p_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      m_q      <= m_d;
      p_q      <= p_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign op_busy = busy_q;
  assign op_done = done_q;
  assign result  = result_q;

endmodule

// File: tb/tb_booth_mult_r4.sv
// Bench for booth_mult_r4 at WIDTH=8 and WIDTH=64.
// Products checked against plain integer multiplication.
module tb_booth_mult_r4;

  localparam int N64 = 2000;
  localparam int N8  = 200;

  logic         clk;
  logic         reset;

  logic         start8, clear8, s8;
  logic [7:0]   a8, b8;
  logic         busy8, done8;
  logic [15:0]  res8;

  logic         start64, clear64, s64;
  logic [63:0]  a64, b64;
  logic         busy64, done64;
  logic [127:0] res64;

  int nvec;
  int nerr;

  booth_mult_r4 #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .reset        (reset),
    .op_start     (start8),
    .op_clear     (clear8),
    .is_signed    (s8),
    .multiplier   (b8),
    .multiplicand (a8),
    .op_busy      (busy8),
    .op_done      (done8),
    .result       (res8)
  );

  booth_mult_r4 #(.WIDTH(64)) dut64 (
    .clk          (clk),
    .reset        (reset),
    .op_start     (start64),
    .op_clear     (clear64),
    .is_signed    (s64),
    .multiplier   (b64),
    .multiplicand (a64),
    .op_busy      (busy64),
    .op_done      (done64),
    .result       (res64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref8(
    input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [17:0] ea, eb, p;
    ea = s ? {{10{a[7]}}, a} : {10'b0, a};
    eb = s ? {{10{b[7]}}, b} : {10'b0, b};
    p  = ea * eb;
    return p[15:0];
  endfunction

  function automatic logic [127:0] ref64(
    input logic [63:0] a, input logic [63:0] b, input logic s);
    logic signed [129:0] ea, eb, p;
    ea = s ? {{66{a[63]}}, a} : {66'b0, a};
    eb = s ? {{66{b[63]}}, b} : {66'b0, b};
    p  = ea * eb;
    return p[127:0];
  endfunction

  // One 8-bit operation; inputs scrambled after acceptance.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic s, input logic [15:0] exp,
                     input string nm);
    int bc;
    bit seen;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; s8 = s;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    nvec++;
    if (res8 !== 16'h0) begin
      nerr++;
      $display("FAIL %s_busy_result: got %h want 0000", nm, res8);
    end
    bc = 0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done8) begin
        seen = 1;
        break;
      end
      if (busy8) bc++;
      @(negedge clk);
    end
    nvec++;
    if (!seen || bc != 5) begin
      nerr++;
      $display("FAIL %s_busy_cycles: got %0d done=%0b want 5 done=1",
               nm, bc, seen);
    end
    nvec++;
    if (res8 !== exp) begin
      nerr++;
      $display("FAIL %s_result: got %h want %h", nm, res8, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start8 = 0; clear8 = 0; s8 = 0; a8 = '0; b8 = '0;
    start64 = 0; clear64 = 0; s64 = 0; a64 = '0; b64 = '0;
    #2 reset = 1'b1;
    #1;
    nvec++;
    if ({busy8, done8, res8} !== 18'h0) begin
      nerr++;
      $display("FAIL reset8: got b=%b d=%b r=%h want 0", busy8, done8, res8);
    end
    nvec++;
    if ({busy64, done64, res64} !== 130'h0) begin
      nerr++;
      $display("FAIL reset64: got b=%b d=%b r=%h want 0",
               busy64, done64, res64);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed8();
    op8(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_min");
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_max_max");
    op8(8'hFF, 8'h7F, 1'b1, 16'hFF81, "s_m1_127");
    op8(8'hFF, 8'h7F, 1'b0, 16'h7E81, "u_255_127");
  endtask

  task automatic test_random8();
    logic [7:0] a, b;
    logic s;
    for (int i = 0; i < N8; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      op8(a, b, s, ref8(a, b, s), "rand8");
    end
  endtask

  task automatic test_start_held8();
    int bc;
    bit seen;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd13; b8 = 8'hF6; s8 = 1'b1;
    bc = 0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done8) begin
        seen = 1;
        break;
      end
      if (busy8) bc++;
    end
    start8 = 1'b0;
    nvec++;
    if (!seen || bc != 5 || res8 !== 16'hFF7E) begin
      nerr++;
      $display("FAIL held_start: got bc=%0d r=%h want 5 ff7e", bc, res8);
    end
    @(negedge clk);
    nvec++;
    if (busy8 !== 1'b0 || done8 !== 1'b1) begin
      nerr++;
      $display("FAIL held_single_op: got b=%b d=%b want b=0 d=1",
               busy8, done8);
    end
  endtask

  task automatic test_abort8();
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd77; b8 = 8'd91; s8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    clear8 = 1'b1;
    @(negedge clk);
    clear8 = 1'b0;
    nvec++;
    if ({busy8, done8, res8} !== 18'h0) begin
      nerr++;
      $display("FAIL abort: got b=%b d=%b r=%h want 0", busy8, done8, res8);
    end
    repeat (8) @(negedge clk);
    nvec++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      nerr++;
      $display("FAIL abort_idle: got b=%b d=%b want 0 0", busy8, done8);
    end
    op8(8'd12, 8'd11, 1'b0, 16'd132, "pre_clear");
    @(negedge clk);
    clear8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    clear8 = 1'b0; start8 = 1'b0;
    nvec++;
    if ({busy8, done8, res8} !== 18'h0) begin
      nerr++;
      $display("FAIL clear_prio: got b=%b d=%b r=%h want 0",
               busy8, done8, res8);
    end
  endtask

  // Back-to-back 64-bit operations with start held; inputs scrambled in BUSY.
  task automatic test_back_to_back64();
    logic [63:0]  a, b;
    logic         s;
    logic [127:0] exp;
    int bc;
    bit seen;
    @(negedge clk);
    for (int i = 0; i < N64; i++) begin
      if (i == 0) begin
        a = 64'h8000_0000_0000_0000; b = a; s = 1'b1;
      end else if (i == 1) begin
        a = '1; b = '1; s = 1'b0;
      end else if (i == 2) begin
        a = '1; b = 64'h7FFF_FFFF_FFFF_FFFF; s = 1'b1;
      end else begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        s = 1'($urandom);
      end
      exp = ref64(a, b, s);
      a64 = a; b64 = b; s64 = s; start64 = 1'b1;
      bc = 0;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (done64) begin
          seen = 1;
          break;
        end
        if (busy64) bc++;
        a64 = {$urandom, $urandom};
        b64 = {$urandom, $urandom};
        s64 = 1'($urandom);
      end
      nvec++;
      if (!seen || bc != 33) begin
        nerr++;
        $display("FAIL b2b_busy[%0d]: got %0d done=%0b want 33 done=1",
                 i, bc, seen);
      end
      nvec++;
      if (res64 !== exp) begin
        nerr++;
        $display("FAIL b2b_result[%0d]: got %h want %h", i, res64, exp);
      end
    end
    start64 = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd3; s8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    nvec++;
    if (busy8 !== 1'b1 || done64 !== 1'b1) begin
      nerr++;
      $display("FAIL pre_reset: got b8=%b d64=%b want 1 1", busy8, done64);
    end
    #2 reset = 1'b1;
    #1;
    nvec++;
    if ({busy8, done8, res8} !== 18'h0) begin
      nerr++;
      $display("FAIL async_reset8: got b=%b d=%b r=%h want 0",
               busy8, done8, res8);
    end
    nvec++;
    if ({busy64, done64, res64} !== 130'h0) begin
      nerr++;
      $display("FAIL async_reset64: got b=%b d=%b r=%h want 0",
               busy64, done64, res64);
    end
    #1 reset = 1'b0;
    op8(8'd3, 8'hFB, 1'b1, 16'hFFF1, "post_reset");
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_directed8();
    test_random8();
    test_start_held8();
    test_abort8();
    test_back_to_back64();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
